// File: rtl/sipo_rx_pkg.sv
// -----------------------------------------------------------------------------
// sipo_rx_pkg
// Shared constants for the serial-in/parallel-out receive controller.
//   DEFAULT_WIDTH : default frame length in bits (legal range 2..32)
//   ST_IDLE       : FSM encoding, waiting for a frame start
//   ST_SHIFT      : FSM encoding, collecting serial bits
// -----------------------------------------------------------------------------
package sipo_rx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // FSM state encoding, kept as plain constants so the state register is an
  // ordinary logic vector.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/sipo_shift_en.sv
// -----------------------------------------------------------------------------
// sipo_shift_en
// WIDTH-bit shift register with shift enable. When en_i is high the register
// takes {q[WIDTH-2:0], d_i}, so the first bit shifted in ends up at the MSB.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears the register
//   en_i : shift enable
//   d_i  : serial data input (enters at bit 0)
//   q_o  : parallel register contents
// -----------------------------------------------------------------------------
module sipo_shift_en
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic src_d;
      logic bit_q;

      // Bit 0 takes the serial input; every other bit takes its neighbour below.
      if (gi == 0) begin : g_head
        assign src_d = d_i;
      end else begin : g_body
        assign src_d = q_o[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bit_q <= 1'b0;
        end else if (en_i) begin
          bit_q <= src_d;
        end
      end

      assign q_o[gi] = bit_q;
    end
  endgenerate

endmodule

// File: rtl/sipo_rx_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_rx_ctrl
// Framing controller for a serial-in/parallel-out receive path. After `start`
// in IDLE it collects exactly WIDTH qualified bits (MSB first), then hands the
// word to a holding register that is presented on a valid/ready handshake.
// A completed word that cannot be accepted because the held word is still
// unconsumed is dropped and the sticky `overrun` flag is set.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : begin a frame (only honoured in IDLE)
//   in_valid  : qualifies `in` this cycle
//   in        : serial data bit, MSB first
//   out_ready : consumer accepts `out` this cycle
//   out       : held parallel word (first bit at out[WIDTH-1])
//   out_valid : `out` holds an unconsumed word
//   busy      : frame in progress
//   overrun   : sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             shift_en;
  logic             complete;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] word;

  // Bits are only accepted while a frame is in progress.
  assign shift_en = (state_q == ST_SHIFT) && in_valid;
  // The completion cycle is the one that samples the WIDTH-th bit.
  assign complete = shift_en && (cnt_q == LAST_CNT);
  // The shift register has not yet absorbed the last bit at the completion
  // edge, so the finished word is assembled from its contents plus `in`.
  assign word = {sr_q[WIDTH-2:0], in};

  sipo_shift_en #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .en_i (shift_en),
    .d_i  (in),
    .q_o  (sr_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (complete) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (shift_en) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (complete) begin
      // A simultaneous consume frees the holding register for the new word.
      if (!out_valid_q || out_ready) begin
        hold_d      = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = hold_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_SHIFT);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx_ctrl
// Directed bench for sipo_rx_ctrl with WIDTH=4. Each vector drives one clock
// cycle of inputs and lists the outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_sipo_rx_ctrl;

  localparam int W = 4;

  typedef struct {
    logic       rst;
    logic       start;
    logic       vld;
    logic       din;
    logic       rdy;
    logic [W-1:0] exp_out;
    logic       exp_ov;
    logic       exp_busy;
    logic       exp_ovr;
    string      name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         din;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  int passed = 0;
  int total  = 0;
  vec_t tbl[$];

  sipo_rx_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in        (din),
    .out_ready (out_ready),
    .out       (dout),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic s, input logic vl,
                             input logic d, input logic rd,
                             input logic [W-1:0] eo, input logic eov,
                             input logic eb, input logic eovr, input string n);
    vec_t t;
    t.rst = r; t.start = s; t.vld = vl; t.din = d; t.rdy = rd;
    t.exp_out = eo; t.exp_ov = eov; t.exp_busy = eb; t.exp_ovr = eovr;
    t.name = n;
    return t;
  endfunction

  task automatic chk(input string n, input string f, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s %s: got %b, expected %b", n, f, act, exp);
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; start = t.start; in_valid = t.vld; din = t.din; out_ready = t.rdy;
    @(posedge clk);
    #1;
    chk(t.name, "out", dout, t.exp_out);
    chk(t.name, "out_valid", W'(out_valid), W'(t.exp_ov));
    chk(t.name, "busy", W'(busy), W'(t.exp_busy));
    chk(t.name, "overrun", W'(overrun), W'(t.exp_ovr));
    $display("%-14s rst=%b start=%b vld=%b in=%b rdy=%b -> out=%b ov=%b busy=%b ovr=%b",
             t.name, t.rst, t.start, t.vld, t.din, t.rdy, dout, out_valid, busy, overrun);
  endtask

  initial begin
    logic [W-1:0] bits3;
    logic [W-1:0] bits6;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; din = 1'b0; out_ready = 1'b0;

    //                 rst st vl d rdy  out     ov bsy ovr
    // Reset with busy-looking inputs, then idle bits that must be ignored.
    tbl.push_back(v(1, 1, 1, 1, 1, 4'b0000, 0, 0, 0, "rst0"));
    tbl.push_back(v(1, 0, 1, 0, 1, 4'b0000, 0, 0, 0, "rst1"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b0000, 0, 0, 0, "idle_bit0"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b0000, 0, 0, 0, "idle_bit1"));
    // Frame 1011, bit on the start cycle not captured.
    tbl.push_back(v(0, 1, 1, 0, 0, 4'b0000, 0, 1, 0, "f1_start"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0, "f1_b0"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b0000, 0, 1, 0, "f1_b1"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0, "f1_b2"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b1011, 1, 0, 0, "f1_b3"));
    // Back-to-back frame 0001 with a consume on the completion cycle.
    tbl.push_back(v(0, 1, 0, 0, 0, 4'b1011, 1, 1, 0, "f2_start"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0, "f2_b0"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0, "f2_b1"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0, "f2_b2"));
    tbl.push_back(v(0, 0, 1, 1, 1, 4'b0001, 1, 0, 0, "f2_b3_rdy"));
    // Reset discards the held word, then reload 1011.
    tbl.push_back(v(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "rst2"));
    tbl.push_back(v(0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, "f3_start"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0, "f3_b0"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b0000, 0, 1, 0, "f3_b1"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0, "f3_b2"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b1011, 1, 0, 0, "f3_b3"));
    // Frame 0001 with no consume: dropped, overrun sticks.
    tbl.push_back(v(0, 1, 0, 0, 0, 4'b1011, 1, 1, 0, "f4_start"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0, "f4_b0"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0, "f4_b1"));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0, "f4_b2"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b1011, 1, 0, 1, "f4_b3_drop"));
    tbl.push_back(v(0, 0, 0, 0, 1, 4'b1011, 0, 0, 1, "consume"));
    tbl.push_back(v(0, 0, 0, 0, 1, 4'b1011, 0, 0, 1, "rdy_no_valid"));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'b1011, 0, 0, 1, "idle_after"));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Frame 0110 with two idle in_valid cycles before every bit.
    apply(v(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "g_rst"));
    apply(v(0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, "g_start"));
    bits3 = 4'b0110;
    for (int b = W - 1; b >= 0; b--) begin
      for (int g = 0; g < 2; g++)
        apply(v(0, 1, 0, 1, 0, 4'b0000, 0, 1, 0, "g_gap"));
      if (b == 0) apply(v(0, 0, 1, bits3[b], 0, 4'b0110, 1, 0, 0, "g_last"));
      else        apply(v(0, 0, 1, bits3[b], 0, 4'b0000, 0, 1, 0, "g_bit"));
    end

    // Reset after two bits of a frame, with 0110 still held.
    apply(v(0, 1, 0, 0, 0, 4'b0110, 1, 1, 0, "p_start"));
    apply(v(0, 0, 1, 1, 0, 4'b0110, 1, 1, 0, "p_b0"));
    apply(v(0, 0, 1, 1, 0, 4'b0110, 1, 1, 0, "p_b1"));
    apply(v(1, 0, 1, 1, 0, 4'b0000, 0, 0, 0, "p_rst"));
    apply(v(0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, "c_start"));
    bits6 = 4'b1100;
    for (int b = W - 1; b >= 0; b--) begin
      if (b == 0) apply(v(0, 0, 1, bits6[b], 0, 4'b1100, 1, 0, 0, "c_last"));
      else        apply(v(0, 0, 1, bits6[b], 0, 4'b0000, 0, 1, 0, "c_bit"));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
# sipo_rx_ctrl

Framing controller for the serial-in/parallel-out shift datapath. It waits for a frame start, then clocks exactly WIDTH qualified serial bits into a shift register. It transfers the completed word to a holding register and presents it on a valid/ready handshake. It sits between a bit-serial source (strobed by `in_valid`) and a word-wide consumer, and flags words lost to back-pressure.

## Interface
- `WIDTH`, default 4: bits per frame and width of `out`; legal range 2..32.

- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a frame; honoured only in IDLE.
- `in_valid`  in  1: qualifies `in` this cycle.
- `in`  in  1: serial data bit, MSB first.
- `out_ready`  in  1: consumer accepts `out` this cycle.
- `out`  out  WIDTH: parallel word; first received bit at `out[WIDTH-1]`, last at `out[0]`.
- `out_valid`  out  1: `out` holds an unconsumed word.
- `busy`  out  1: frame in progress (state SHIFT).
- `overrun`  out  1: sticky; a completed word was dropped.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: `busy`=0, bit counter held at 0, `in`/`in_valid` ignored. `start`=1 moves to SHIFT. The bit on the `start` cycle is not captured.
- SHIFT: `busy`=1, `start` ignored.
  - Each cycle with `in_valid`=1: shift register updates to {sr[WIDTH-2:0], in} and the counter increments.
  - `in_valid`=0: shift register and counter hold. There is no timeout.
- Completion: the cycle that samples the WIDTH-th bit is the completion cycle. At that edge:
  - the FSM goes to IDLE, the counter clears, and the completed word (including that bit) is offered to the holding register.
- Holding-register load rules at the completion edge:
  - `out_valid`=0: load the word, set `out_valid`=1.
  - `out_valid`=1 and `out_ready`=1 in the same cycle: the old word is consumed, the new word loads, `out_valid` stays 1, no overrun.
  - `out_valid`=1 and `out_ready`=0: the new word is dropped, `out` is unchanged and `overrun` sets.
- Consumption: with `out_valid`=1 and `out_ready`=1 and no completion in that cycle, `out_valid` clears next edge. `out` retains its last value.
- `out_ready` while `out_valid`=0 has no effect.
- `overrun` clears only on `rst`.
- Counter width: $clog2(WIDTH+1) bits. The counter never wraps; it is reset on completion.

## Timing
- Reset values (asynchronous, immediate): state IDLE, counter 0, shift register 0, `out`=0, `out_valid`=0, `busy`=0, `overrun`=0.
- Reset mid-frame discards the partial word. Reset with `out_valid`=1 discards the held word.
- `start` sampled at edge k (in IDLE): `busy`=1 from after edge k.
- With `in_valid`=1 continuously from edge k+1, the last bit is sampled at edge k+WIDTH. After that edge, `out_valid`=1, `out` is valid and `busy`=0.
- Best-case frame-to-frame spacing: `start` may be asserted in the first IDLE cycle, giving WIDTH+1 cycles per word.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `sipo_rx_pkg`: FSM state enum (IDLE, SHIFT) and the default WIDTH constant.
- Sub-module `sipo_shift_en`:
  - WIDTH-parameterised shift register with shift-enable and async active-high reset;
  - shifts {q[WIDTH-2:0], d} when enabled.
- The controller instantiates `sipo_shift_en` and owns the FSM, counter, holding register and flags.

## Test plan
All scenarios use WIDTH=4.
1. Assert `rst` for 2 cycles with random inputs → all outputs 0, state IDLE; bits presented in IDLE without `start` leave `out`=0 and `out_valid`=0.
2. `start`, then bits 1,0,1,1 on consecutive `in_valid` cycles, `out_ready`=0 → after the 4th bit edge `out`=4'b1011, `out_valid`=1, `busy`=0; the total is 5 cycles from `start`.
3. `start`, then bits 0,1,1,0 with `in_valid` low for 2 cycles between each bit → `out`=4'b0110 after the last valid bit; `busy` stays 1 throughout the gaps.
4. With 4'b1011 held (`out_ready`=0), send a full frame 0,0,0,1 → `out` stays 4'b1011, `overrun`=1; `overrun` is still 1 after later consumption.
5. With 4'b1011 held, complete frame 0,0,0,1 with `out_ready`=1 on the completion cycle → `out`=4'b0001, `out_valid` remains 1, `overrun`=0.
6. Assert `rst` after 2 bits of a frame → outputs zero, state IDLE; a following frame 1,1,0,0 yields `out`=4'b1100 with no contamination from the partial frame.
